// File: rtl/tagger_pkg.sv
// Shared constants and types for the strobe front-end and event tagger.
package tagger_pkg;

  localparam int N_CHANNELS_DEFAULT  = 100;
  localparam int DEADTIME_W_DEFAULT  = 8;
  localparam int SYNC_STAGES_DEFAULT = 2;

  typedef enum logic {
    EDGE_RISING  = 1'b0,
    EDGE_FALLING = 1'b1
  } edge_pol_e;

endpackage

// File: rtl/strobe_conditioner_if.sv
// Control/status bundle between the strobe pins, the register block and the tagger.
interface strobe_conditioner_if
  import tagger_pkg::*;
#(
  parameter int N_CHANNELS = N_CHANNELS_DEFAULT,
  parameter int DEADTIME_W = DEADTIME_W_DEFAULT
);

  logic [N_CHANNELS-1:0] strobe_in;
  logic [N_CHANNELS-1:0] channel_en;
  logic [N_CHANNELS-1:0] edge_sel;
  logic [DEADTIME_W-1:0] deadtime;
  logic                  clear_drops;
  logic [N_CHANNELS-1:0] strobe_out;
  logic [N_CHANNELS-1:0] drop_flag;
  logic                  armed;

  modport master (
    output strobe_in, channel_en, edge_sel, deadtime, clear_drops,
    input  strobe_out, drop_flag, armed
  );

  modport slave (
    input  strobe_in, channel_en, edge_sel, deadtime, clear_drops,
    output strobe_out, drop_flag, armed
  );

endinterface

// File: rtl/strobe_channel_cond.sv
// One strobe channel: resynchroniser, edge detect, dead-time hold-off and sticky drop flag.
module strobe_channel_cond
  import tagger_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT,
  parameter int DEADTIME_W  = DEADTIME_W_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  strobe_in,
  input  logic                  channel_en,
  input  logic                  edge_sel,
  input  logic                  armed,
  input  logic [DEADTIME_W-1:0] deadtime,
  input  logic                  clear_drops,
  output logic                  strobe_out,
  output logic                  drop_flag
);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   prev_reg;
  logic [DEADTIME_W-1:0]  cnt_reg, cnt_next;
  logic                   strobe_out_reg;
  logic                   drop_flag_reg, drop_flag_next;

  logic sync_level;
  logic edge_det;
  logic qualified;
  logic idle;
  logic accept;
  logic drop;

  assign sync_level = sync_reg[SYNC_STAGES-1];

  always_comb begin
    edge_det       = 1'b0;
    qualified      = 1'b0;
    idle           = 1'b0;
    accept         = 1'b0;
    drop           = 1'b0;
    cnt_next       = cnt_reg;
    drop_flag_next = drop_flag_reg;

    // Edges come only from sync/prev, so flipping polarity on a steady line is inert.
    if (edge_pol_e'(edge_sel) == EDGE_FALLING) begin
      edge_det = ~sync_level & prev_reg;
    end else begin
      edge_det = sync_level & ~prev_reg;
    end

    qualified = edge_det & channel_en & armed;
    idle      = (cnt_reg == '0);
    accept    = qualified & idle;
    drop      = qualified & ~idle;

    if (!channel_en) begin
      cnt_next = '0;
    end else if (accept) begin
      cnt_next = deadtime;
    end else if (!idle) begin
      cnt_next = cnt_reg - DEADTIME_W'(1);
    end

    // A drop in the same cycle as a clear keeps the flag set.
    drop_flag_next = drop | (drop_flag_reg & ~clear_drops);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_reg       <= '0;
      prev_reg       <= 1'b0;
      cnt_reg        <= '0;
      strobe_out_reg <= 1'b0;
      drop_flag_reg  <= 1'b0;
    end else begin
      sync_reg       <= {sync_reg[SYNC_STAGES-2:0], strobe_in};
      prev_reg       <= sync_level;
      cnt_reg        <= cnt_next;
      strobe_out_reg <= accept;
      drop_flag_reg  <= drop_flag_next;
    end
  end

  assign strobe_out = strobe_out_reg;
  assign drop_flag  = drop_flag_reg;

endmodule

// File: rtl/strobe_conditioner.sv
// Strobe front-end: N independent channel conditioners plus the shared post-reset warm-up gate.
module strobe_conditioner
  import tagger_pkg::*;
#(
  parameter int N_CHANNELS  = N_CHANNELS_DEFAULT,
  parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT,
  parameter int DEADTIME_W  = DEADTIME_W_DEFAULT
) (
  input logic                clk,
  input logic                reset,
  strobe_conditioner_if.slave bus
);

  localparam int WARM_W = $clog2(SYNC_STAGES + 2);

  logic [WARM_W-1:0]     warm_cnt_reg;
  logic                  armed_reg;
  logic [N_CHANNELS-1:0] strobe_out_w;
  logic [N_CHANNELS-1:0] drop_flag_w;

  // Warm-up spans the sync chain plus prev, so a line held active through reset never pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      warm_cnt_reg <= '0;
      armed_reg    <= 1'b0;
    end else begin
      if (!armed_reg) begin
        warm_cnt_reg <= warm_cnt_reg + WARM_W'(1);
      end
      armed_reg <= armed_reg | (warm_cnt_reg == WARM_W'(SYNC_STAGES));
    end
  end

  for (genvar gi = 0; gi < N_CHANNELS; gi++) begin : g_chan
    strobe_channel_cond #(
      .SYNC_STAGES (SYNC_STAGES),
      .DEADTIME_W  (DEADTIME_W)
    ) u_chan (
      .clk         (clk),
      .reset       (reset),
      .strobe_in   (bus.strobe_in[gi]),
      .channel_en  (bus.channel_en[gi]),
      .edge_sel    (bus.edge_sel[gi]),
      .armed       (armed_reg),
      .deadtime    (bus.deadtime),
      .clear_drops (bus.clear_drops),
      .strobe_out  (strobe_out_w[gi]),
      .drop_flag   (drop_flag_w[gi])
    );
  end

  assign bus.strobe_out = strobe_out_w;
  assign bus.drop_flag  = drop_flag_w;
  assign bus.armed      = armed_reg;

endmodule
